cpuif_arbiter: RTL and testbench

Shares one regblock generic CPU interface (cpuif_*) between NUM_REQ independent requesters, for example a host bus bridge and a debug or BIST master. It uses round-robin arbitration with one outstanding transaction at a time. Each transaction is latched and issued to the regblock with stall handling. The response is routed back only to the granted requester. A timeout converts a missing ack into an error response. The block sits between the requester bridges and the generated regblock, in both the SV and VHDL flows.

---
 rtl/cpuif_arbiter_pkg.sv | 22 ++
 rtl/cpuif_arbiter_rr.sv | 35 +++
 rtl/cpuif_arbiter.sv | 138 +++++++++++++
 tb/tb_cpuif_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpuif_arbiter_pkg.sv
// rtl/cpuif_arbiter_pkg.sv - shared types for the cpuif round-robin arbiter
package cpuif_arbiter_pkg;

  localparam int MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef struct packed {
    logic                 is_wr;
    logic [MAX_IDX_W-1:0] idx;
  } cap_req_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpuif_arbiter_rr.sv
// rtl/cpuif_arbiter_rr.sv - combinational round-robin pick, rr_ptr has top priority
module rr_arbiter
  import cpuif_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  function automatic int wrap_add(input int base, input int ofs);
    int s;
    s = base + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[wrap_add(int'(rr_ptr), k)]) begin
        any                                 = 1'b1;
        grant[wrap_add(int'(rr_ptr), k)]    = 1'b1;
        grant_idx                           = IDX_W'(wrap_add(int'(rr_ptr), k));
      end
    end
  end

endmodule

// File: rtl/cpuif_arbiter.sv
// rtl/cpuif_arbiter.sv - shares one regblock cpuif between NUM_REQ requesters
module cpuif_arbiter
  import cpuif_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [NUM_REQ-1:0]            m_req,
  input  logic [NUM_REQ-1:0]            m_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] m_wr_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] m_wr_biten,
  output logic [NUM_REQ-1:0]            m_ack,
  output logic                          m_err,
  output logic [DATA_WIDTH-1:0]         m_rd_data,
  output logic                          cpuif_req,
  output logic                          cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]         cpuif_addr,
  output logic [DATA_WIDTH-1:0]         cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]         cpuif_wr_biten,
  input  logic                          cpuif_req_stall_wr,
  input  logic                          cpuif_req_stall_rd,
  input  logic                          cpuif_rd_ack,
  input  logic                          cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]         cpuif_rd_data,
  input  logic                          cpuif_wr_ack,
  input  logic                          cpuif_wr_err
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_e           state;
  cap_req_t             cap;
  logic [NUM_REQ-1:0]   cap_oh;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     next_ptr;
  logic                 any_req;
  logic [CNT_W-1:0]     cnt;
  logic                 cur_stall;
  logic                 cur_ack;
  logic                 cur_err;
  logic                 timed_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (m_req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Only the handshake matching the latched direction is ever looked at.
  always_comb begin
    cur_stall = cap.is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    cur_ack   = cap.is_wr ? cpuif_wr_ack : cpuif_rd_ack;
    cur_err   = cap.is_wr ? cpuif_wr_err : cpuif_rd_err;
    timed_out = (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT - 1);
    next_ptr  = (int'(cap.idx) >= NUM_REQ - 1) ? '0 : IDX_W'(int'(cap.idx) + 1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      cnt             <= '0;
      cap             <= '0;
      cap_oh          <= '0;
      cpuif_req       <= 1'b0;
      cpuif_req_is_wr <= 1'b0;
      cpuif_addr      <= '0;
      cpuif_wr_data   <= '0;
      cpuif_wr_biten  <= '0;
      m_ack           <= '0;
      m_err           <= 1'b0;
      m_rd_data       <= '0;
    end else begin
      m_ack     <= '0;
      m_err     <= 1'b0;
      m_rd_data <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cap_oh          <= grant;
            cap.idx         <= MAX_IDX_W'(grant_idx);
            cap.is_wr       <= m_is_wr[grant_idx];
            cpuif_req_is_wr <= m_is_wr[grant_idx];
            cpuif_addr      <= m_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            cpuif_wr_data   <= m_wr_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            cpuif_wr_biten  <= m_wr_biten[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            cpuif_req       <= 1'b1;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!cur_stall) begin
            cpuif_req <= 1'b0;
            cnt       <= '0;
            if (cur_ack) begin
              m_ack     <= cap_oh;
              m_err     <= cur_err;
              m_rd_data <= cap.is_wr ? '0 : cpuif_rd_data;
              state     <= ST_RESP;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A real ack beats a timeout landing on the same cycle.
          if (cur_ack) begin
            m_ack     <= cap_oh;
            m_err     <= cur_err;
            m_rd_data <= cap.is_wr ? '0 : cpuif_rd_data;
            state     <= ST_RESP;
          end else if (timed_out) begin
            m_ack <= cap_oh;
            m_err <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuif_arbiter.sv
// tb/tb_cpuif_arbiter.sv - directed self-checking bench for cpuif_arbiter
module tb_cpuif_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  m_req;
  logic [1:0]  m_is_wr;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] biten_v [2];
  logic [63:0] m_addr;
  logic [63:0] m_wr_data;
  logic [63:0] m_wr_biten;
  logic [1:0]  m_ack;
  logic        m_err;
  logic [31:0] m_rd_data;
  logic        cpuif_req;
  logic        cpuif_req_is_wr;
  logic [31:0] cpuif_addr;
  logic [31:0] cpuif_wr_data;
  logic [31:0] cpuif_wr_biten;
  logic        stall_wr;
  logic        stall_rd;
  logic        rd_ack;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        wr_ack;
  logic        wr_err;

  int n_checks = 0;
  int n_errors = 0;

  assign m_addr     = {addr_v[1], addr_v[0]};
  assign m_wr_data  = {wdata_v[1], wdata_v[0]};
  assign m_wr_biten = {biten_v[1], biten_v[0]};

  always #5 clk = ~clk;

  cpuif_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .m_req              (m_req),
    .m_is_wr            (m_is_wr),
    .m_addr             (m_addr),
    .m_wr_data          (m_wr_data),
    .m_wr_biten         (m_wr_biten),
    .m_ack              (m_ack),
    .m_err              (m_err),
    .m_rd_data          (m_rd_data),
    .cpuif_req          (cpuif_req),
    .cpuif_req_is_wr    (cpuif_req_is_wr),
    .cpuif_addr         (cpuif_addr),
    .cpuif_wr_data      (cpuif_wr_data),
    .cpuif_wr_biten     (cpuif_wr_biten),
    .cpuif_req_stall_wr (stall_wr),
    .cpuif_req_stall_rd (stall_rd),
    .cpuif_rd_ack       (rd_ack),
    .cpuif_rd_err       (rd_err),
    .cpuif_rd_data      (rd_data),
    .cpuif_wr_ack       (wr_ack),
    .cpuif_wr_err       (wr_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (cpuif_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, cpuif_req}, 64'd1);
  endtask

  initial begin
    int          lat;
    logic [1:0]  exp_oh;
    logic [31:0] exp_addr;

    arst_n   = 1'b0;
    m_req    = '0;
    m_is_wr  = '0;
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
      biten_v[i] = '0;
    end
    stall_wr = 1'b0; stall_rd = 1'b0;
    rd_ack = 1'b0; rd_err = 1'b0; rd_data = '0;
    wr_ack = 1'b0; wr_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_ack", {62'd0, m_ack}, 64'd0);
    chk("rst_cpuif_req", {63'd0, cpuif_req}, 64'd0);
    chk("rst_cpuif_addr", {32'd0, cpuif_addr}, 64'd0);
    chk("rst_m_rd_data", {32'd0, m_rd_data}, 64'd0);
    arst_n = 1'b1;

    // Single read, same-cycle ack: m_ack two cycles after arbitration
    @(negedge clk);
    m_req = 2'b01; m_is_wr = 2'b00; addr_v[0] = 32'h10;
    @(negedge clk);
    chk("rd_issue_req", {63'd0, cpuif_req}, 64'd1);
    chk("rd_issue_addr", {32'd0, cpuif_addr}, 64'h10);
    chk("rd_issue_is_wr", {63'd0, cpuif_req_is_wr}, 64'd0);
    rd_ack = 1'b1; rd_data = 32'hDEADBEEF;
    @(negedge clk);
    rd_ack = 1'b0; rd_data = '0; m_req = 2'b00;
    chk("rd_m_ack", {62'd0, m_ack}, 64'b01);
    chk("rd_m_rd_data", {32'd0, m_rd_data}, 64'hDEADBEEF);
    chk("rd_m_err", {63'd0, m_err}, 64'd0);
    @(negedge clk);
    chk("rd_ack_one_cycle", {62'd0, m_ack}, 64'd0);

    // Stalled write from requester 1: cpuif_req high for 4 cycles
    m_req = 2'b10; m_is_wr = 2'b10;
    addr_v[1] = 32'h44; wdata_v[1] = 32'hCAFE0001; biten_v[1] = 32'hFFFFFFFF;
    stall_wr = 1'b1;
    wait_req("st_req_rise");
    for (int c = 0; c < 4; c++) begin
      if (c == 3) stall_wr = 1'b0;
      chk($sformatf("st_req_c%0d", c), {63'd0, cpuif_req}, 64'd1);
      chk($sformatf("st_addr_c%0d", c), {32'd0, cpuif_addr}, 64'h44);
      if (c < 3) @(negedge clk);
      if (c == 0) addr_v[1] = 32'h99;
    end
    chk("st_wdata", {32'd0, cpuif_wr_data}, 64'hCAFE0001);
    @(negedge clk);
    chk("st_req_drop", {63'd0, cpuif_req}, 64'd0);
    chk("st_no_early_ack", {62'd0, m_ack}, 64'd0);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0; m_req = 2'b00;
    chk("st_m_ack", {62'd0, m_ack}, 64'b10);
    chk("st_m_rd_data", {32'd0, m_rd_data}, 64'd0);
    @(negedge clk);

    // Contention: both requesting, grants alternate 0,1,0,1
    m_req = 2'b11; m_is_wr = 2'b00;
    addr_v[0] = 32'h100; addr_v[1] = 32'h200;
    for (int t = 0; t < 4; t++) begin
      exp_oh   = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 32'h100 : 32'h200;
      wait_req($sformatf("ct_req_%0d", t));
      chk($sformatf("ct_addr_%0d", t), {32'd0, cpuif_addr}, {32'd0, exp_addr});
      rd_ack = 1'b1; rd_data = exp_addr ^ 32'h5A5A0000;
      @(negedge clk);
      rd_ack = 1'b0;
      if (t == 3) m_req = 2'b00;
      chk($sformatf("ct_ack_%0d", t), {62'd0, m_ack}, {62'd0, exp_oh});
      chk($sformatf("ct_data_%0d", t), {32'd0, m_rd_data}, {32'd0, exp_addr ^ 32'h5A5A0000});
      chk($sformatf("ct_no_overlap_%0d", t), {63'd0, cpuif_req}, 64'd0);
    end
    @(negedge clk);

    // Timeout: read with no ack completes with error 8 cycles after acceptance
    m_req = 2'b01; m_is_wr = 2'b00; addr_v[0] = 32'h300;
    wait_req("to_req");
    lat = 0;
    while (m_ack === 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    m_req = 2'b00;
    chk("to_latency", 64'(lat), 64'd8);
    chk("to_m_ack", {62'd0, m_ack}, 64'b01);
    chk("to_m_err", {63'd0, m_err}, 64'd1);
    chk("to_m_rd_data", {32'd0, m_rd_data}, 64'd0);
    @(negedge clk);
    rd_ack = 1'b1; rd_data = 32'h1234;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("to_stray_ack", {62'd0, m_ack}, 64'd0);
    chk("to_stray_req", {63'd0, cpuif_req}, 64'd0);

    // Write error pass-through; wrong-type ack ignored
    m_req = 2'b01; m_is_wr = 2'b01;
    addr_v[0] = 32'h20; wdata_v[0] = 32'h12345678; biten_v[0] = 32'h0000FFFF;
    wait_req("we_req");
    chk("we_is_wr", {63'd0, cpuif_req_is_wr}, 64'd1);
    chk("we_wdata", {32'd0, cpuif_wr_data}, 64'h12345678);
    chk("we_biten", {32'd0, cpuif_wr_biten}, 64'h0000FFFF);
    @(negedge clk);
    rd_ack = 1'b1; rd_data = 32'hFFFF;
    @(negedge clk);
    chk("we_wrong_type", {62'd0, m_ack}, 64'd0);
    rd_ack = 1'b0; rd_data = '0;
    wr_ack = 1'b1; wr_err = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0; wr_err = 1'b0; m_req = 2'b00;
    chk("we_m_ack", {62'd0, m_ack}, 64'b01);
    chk("we_m_err", {63'd0, m_err}, 64'd1);
    chk("we_m_rd_data", {32'd0, m_rd_data}, 64'd0);
    @(negedge clk);

    // Reset mid-WAIT, then requester 0 wins despite rr_ptr having been 1
    m_req = 2'b10; m_is_wr = 2'b00; addr_v[1] = 32'h400;
    wait_req("rs_req");
    chk("rs_addr", {32'd0, cpuif_addr}, 64'h400);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("rs_async_addr", {32'd0, cpuif_addr}, 64'd0);
    chk("rs_async_req", {63'd0, cpuif_req}, 64'd0);
    chk("rs_async_ack", {62'd0, m_ack}, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    m_req = 2'b11; addr_v[0] = 32'h500;
    rd_ack = 1'b1; rd_data = 32'hBAD;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("rs_regrant_req", {63'd0, cpuif_req}, 64'd1);
    chk("rs_regrant_addr", {32'd0, cpuif_addr}, 64'h500);
    chk("rs_stray_dropped", {62'd0, m_ack}, 64'd0);
    rd_ack = 1'b1; rd_data = 32'h0000A5A5;
    @(negedge clk);
    rd_ack = 1'b0; m_req = 2'b00;
    chk("rs_m_ack", {62'd0, m_ack}, 64'b01);
    chk("rs_m_rd_data", {32'd0, m_rd_data}, 64'hA5A5);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
